psram_resp: RTL and testbench
=============================

PSRAM_RESP -- requirements
Module: psram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 8; word-address width of the internal store (2^ADDR_W x 16-bit words).
REQ-002 SHALL have parameter RD_LAT, default 5; read/MRR latency in spi_clk periods.
REQ-003 SHALL have parameter MR1_ID, default 8'h0D; vendor ID returned from MR1.
REQ-004 SHALL have parameter MR2_ID, default 8'h93; device ID returned from MR2.
REQ-005 SHALL have port clk  in  1  sampling clock (the clk4 domain), at least 4x spi_clk.
REQ-006 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port spi_cs  in  1  chip select, active high.
REQ-008 SHALL have port spi_clk  in  1  memory clock level, sampled on clk.
REQ-009 SHALL have port spi_data_in  in  8  DQ from initiator.
REQ-010 SHALL have port spi_data_out  out  8  DQ to initiator.
REQ-011 SHALL have port spi_data_oe  out  1  DQ drive enable.
REQ-012 SHALL have port spi_rwds_in  in  1  write byte mask (1 = masked).
REQ-013 SHALL have port spi_rwds_out  out  1  read strobe.
REQ-014 SHALL have port spi_rwds_oe  out  1  RWDS drive enable.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-016 SHALL have port err  out  1  sticky protocol error.

Function
REQ-017 SHALL register spi_clk once; each rise or fall of spi_clk while spi_cs is high is one beat; DQ and RWDS are sampled on the clk cycle that detects the beat.
REQ-018 SHALL have states IDLE, CMD, ADDR, LAT, RDATA, WDATA, MRW, WAITCS.
- IDLE -> CMD when spi_cs rises.
- CMD takes 2 beats; both beats must be equal.
- Commands: 8'h00 = read, 8'h80 = write, 8'h40 = MRR, 8'hC0 = MRW, 8'hFF = reset.
REQ-019 Reset command (8'hFF) SHALL restore all MR defaults and then go to WAITCS.
REQ-020 SHALL, on a mismatched or unknown command, set err and go to WAITCS; err clears only on reset_n.
REQ-021 ADDR SHALL take 4 beats, MSB first, forming a 32-bit byte address; word address = bits [ADDR_W:1]; bit 0 and the upper bits are ignored.
REQ-022 Read and MRR SHALL pass through LAT for exactly 2*RD_LAT beats.
- During LAT: spi_rwds_oe = 1, spi_rwds_out = 0, spi_data_oe = 1.
REQ-023 Write SHALL pass through LAT for 2*RD_LAT beats with all outputs undriven; MRW SHALL skip LAT.
REQ-024 RDATA SHALL output 2 beats per word: the even (low) byte on the rise beat, the odd byte on the fall beat.
- spi_data_out updates one clk after the preceding beat.
- spi_rwds_out = 1 for a low byte, 0 for a high byte.
REQ-025 WDATA SHALL commit each byte on its own beat unless spi_rwds_in = 1 on that beat.
REQ-026 The word address SHALL increment after every odd byte and wrap from 2^ADDR_W-1 to 0.
REQ-027 The first read word SHALL be fetched at the end of ADDR, so the first data beat incurs no extra latency.
REQ-028 Mode registers (MRR / MRW):
- MRR selects MR by address bits [3:0] and returns the MR value on every beat.
- MR1 = MR1_ID and MR2 = MR2_ID are read-only; MR0 and MR4 are read/write with reset value 8'h00; all others read 8'h00.
- MRW writes the first data beat, then goes to WAITCS.
REQ-029 spi_cs falling in any state SHALL force IDLE on the next clk and drop both output enables; bytes already committed remain.
REQ-030 A rise and fall in the same clk SHALL NOT occur; this is guaranteed by the clock ratio and is not checked.

Reset
REQ-031 reset_n low SHALL asynchronously force:
- state = IDLE;
- spi_data_out, spi_data_oe, spi_rwds_out, spi_rwds_oe, busy and err all 0;
- MR0 and MR4 = 8'h00.
REQ-032 Store contents SHALL be undefined after reset; store contents are not reset.

Structure
REQ-033 Package psram_pkg SHALL hold the state enum, the command constants (CMD_RD, CMD_WR, CMD_MRR, CMD_MRW, CMD_RST) and the MR indices, shared with psram_ctrl.
REQ-034 The store SHALL be sub-module psram_resp_mem:
- byte-enabled write;
- 1-cycle registered read;
- single clk.

Verification
REQ-035 Reset then MRR of MR1 with RD_LAT = 5 -> after 10 LAT beats, DQ = 8'h0D on both beats and RWDS toggles 1,0; err = 0.
REQ-036 Write 8 bytes 11..88 to byte address 0x1FC with RWDS high on the 3rd byte, then read 8 bytes from 0x1FC -> read returns 11,22,old,44,55,66,77,88, with wrap from word 0xFF to word 0x00 (ADDR_W = 8).
REQ-037 Command beats 0x00 then 0x80 -> err = 1, no DQ/RWDS drive until CS drops; err stays 1 on later valid transactions.
REQ-038 spi_cs dropped mid-read after 3 data beats -> spi_data_oe = 0 and busy = 0 within 2 clk; the next read from the same address returns the correct data.
REQ-039 MRW MR0 = 8'h5A, then 8'hFF reset command, then MRR MR0 -> 8'h00; MRW to MR1 leaves MR1 = 8'h0D.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM responder: FSM states, command
// opcodes and mode-register indices.
package psram_pkg;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, LAT, RDATA, WDATA, MRW, WAITCS
  } state_t;

  localparam logic [7:0] CMD_RD  = 8'h00;
  localparam logic [7:0] CMD_WR  = 8'h80;
  localparam logic [7:0] CMD_MRR = 8'h40;
  localparam logic [7:0] CMD_MRW = 8'hC0;
  localparam logic [7:0] CMD_RST = 8'hFF;

  localparam logic [3:0] MR0_IDX = 4'd0;
  localparam logic [3:0] MR1_IDX = 4'd1;
  localparam logic [3:0] MR2_IDX = 4'd2;
  localparam logic [3:0] MR4_IDX = 4'd4;

  function automatic logic is_known_cmd(input logic [7:0] c);
    return (c == CMD_RD) || (c == CMD_WR) || (c == CMD_MRR) ||
           (c == CMD_MRW) || (c == CMD_RST);
  endfunction

endpackage

// File: rtl/psram_resp_mem.sv
// 16-bit word store with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module psram_resp_mem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we && be[0]) mem[waddr][7:0]  <= wdata[7:0];
    if (we && be[1]) mem[waddr][15:8] <= wdata[15:8];
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/psram_resp.sv
// PSRAM target model: decodes command/address beats from an oversampled
// memory clock and serves reads, writes and mode-register accesses.
//
// state  | meaning
// IDLE   | chip deselected
// CMD    | two identical command beats
// ADDR   | four address beats, MSB first
// LAT    | 2*RD_LAT latency beats (driven low for reads/MRR)
// RDATA  | streaming read or MRR data
// WDATA  | streaming masked write data
// MRW    | one mode-register write beat
// WAITCS | done or errored, waiting for chip select to drop
module psram_resp #(
  parameter int         ADDR_W = 8,
  parameter int         RD_LAT = 5,
  parameter logic [7:0] MR1_ID = 8'h0D,
  parameter logic [7:0] MR2_ID = 8'h93
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_cs,
  input  logic       spi_clk,
  input  logic [7:0] spi_data_in,
  output logic [7:0] spi_data_out,
  output logic       spi_data_oe,
  input  logic       spi_rwds_in,
  output logic       spi_rwds_out,
  output logic       spi_rwds_oe,
  output logic       busy,
  output logic       err
);
  import psram_pkg::*;

  localparam int CNT_W = (2*RD_LAT > 4) ? $clog2(2*RD_LAT) : 2;

  state_t            state, state_d;
  logic              spi_clk_q, beat;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [23:0]       addr_sh, addr_sh_d;
  logic [31:0]       addr_full;
  logic [ADDR_W-1:0] word_addr, word_addr_d;
  logic              hi_sel, hi_sel_d;
  logic [3:0]        mr_idx, mr_idx_d;
  logic [7:0]        mr0, mr0_d, mr4, mr4_d, mr_val;
  logic              err_q, err_d;
  logic              mem_we, rd_drive, unused_addr;
  logic [15:0]       mem_rdata;

  assign beat        = spi_cs & (spi_clk ^ spi_clk_q);
  assign addr_full   = {addr_sh, spi_data_in};
  assign unused_addr = ^addr_full[31:ADDR_W+1];

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    cmd_d       = cmd_q;
    addr_sh_d   = addr_sh;
    word_addr_d = word_addr;
    hi_sel_d    = hi_sel;
    mr_idx_d    = mr_idx;
    mr0_d       = mr0;
    mr4_d       = mr4;
    err_d       = err_q;
    mem_we      = 1'b0;
    case (state)
      IDLE: if (spi_cs) begin
        state_d = CMD;
        cnt_d   = CNT_W'(1);
      end
      CMD: if (beat) begin
        if (cnt != '0) begin
          cmd_d = spi_data_in;
          cnt_d = '0;
        end else if (spi_data_in != cmd_q || !is_known_cmd(cmd_q)) begin
          err_d   = 1'b1;
          state_d = WAITCS;
        end else if (cmd_q == CMD_RST) begin
          mr0_d   = 8'h00;
          mr4_d   = 8'h00;
          state_d = WAITCS;
        end else begin
          state_d = ADDR;
          cnt_d   = CNT_W'(3);
        end
      end
      ADDR: if (beat) begin
        addr_sh_d = addr_full[23:0];
        cnt_d     = cnt - 1'b1;
        if (cnt == '0) begin
          word_addr_d = addr_full[ADDR_W:1];
          mr_idx_d    = addr_full[3:0];
          hi_sel_d    = 1'b0;
          cnt_d       = CNT_W'(2*RD_LAT-1);
          state_d     = (cmd_q == CMD_MRW) ? MRW : LAT;
        end
      end
      LAT: if (beat) begin
        if (cnt == '0) state_d = (cmd_q == CMD_WR) ? WDATA : RDATA;
        else           cnt_d   = cnt - 1'b1;
      end
      RDATA, WDATA: if (beat) begin
        mem_we   = (state == WDATA) && !spi_rwds_in;
        hi_sel_d = ~hi_sel;
        if (hi_sel) word_addr_d = word_addr + 1'b1;
      end
      MRW: if (beat) begin
        if (mr_idx == MR0_IDX)      mr0_d = spi_data_in;
        else if (mr_idx == MR4_IDX) mr4_d = spi_data_in;
        state_d = WAITCS;
      end
      default: ;
    endcase
    if (!spi_cs) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      spi_clk_q <= 1'b0;
      cnt       <= '0;
      cmd_q     <= 8'h00;
      addr_sh   <= '0;
      word_addr <= '0;
      hi_sel    <= 1'b0;
      mr_idx    <= 4'h0;
      mr0       <= 8'h00;
      mr4       <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      spi_clk_q <= spi_clk;
      cnt       <= cnt_d;
      cmd_q     <= cmd_d;
      addr_sh   <= addr_sh_d;
      word_addr <= word_addr_d;
      hi_sel    <= hi_sel_d;
      mr_idx    <= mr_idx_d;
      mr0       <= mr0_d;
      mr4       <= mr4_d;
      err_q     <= err_d;
    end
  end

  // Reading from the next-state address keeps the word ready one clk after the beat.
  psram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (hi_sel ? 2'b10 : 2'b01),
    .waddr (word_addr),
    .wdata ({spi_data_in, spi_data_in}),
    .raddr (word_addr_d),
    .rdata (mem_rdata)
  );

  always_comb begin
    case (mr_idx)
      MR0_IDX: mr_val = mr0;
      MR1_IDX: mr_val = MR1_ID;
      MR2_IDX: mr_val = MR2_ID;
      MR4_IDX: mr_val = mr4;
      default: mr_val = 8'h00;
    endcase
  end

  assign rd_drive     = (state == LAT && cmd_q != CMD_WR) || state == RDATA;
  assign spi_data_oe  = rd_drive;
  assign spi_rwds_oe  = rd_drive;
  assign spi_rwds_out = (state == RDATA) && !hi_sel;
  assign spi_data_out = (state != RDATA) ? 8'h00 :
                        (cmd_q == CMD_MRR) ? mr_val :
                        hi_sel ? mem_rdata[15:8] : mem_rdata[7:0];
  assign busy = (state != IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_psram_resp.sv
// Self-checking bench for psram_resp: directed scenarios plus random
// transactions checked against a byte-array / mode-register model.
module tb_psram_resp;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 5;
  localparam int NB     = 2**(ADDR_W+1);

  logic       clk = 1'b0, reset_n = 1'b0, spi_cs = 1'b0, spi_clk = 1'b0;
  logic [7:0] spi_data_in = 8'h00;
  logic       spi_rwds_in = 1'b0;
  logic [7:0] spi_data_out;
  logic       spi_data_oe, spi_rwds_out, spi_rwds_oe, busy, err;

  int checks = 0, failures = 0;

  logic [7:0] mem_m [NB];
  bit         vld_m [NB];
  logic [7:0] mr0_m = 8'h00, mr4_m = 8'h00;
  bit         err_m = 1'b0;
  logic [7:0] wd [8];
  bit         wm [8];

  psram_resp #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MR1_ID(8'h0D), .MR2_ID(8'h93)) dut (
    .clk(clk), .reset_n(reset_n), .spi_cs(spi_cs), .spi_clk(spi_clk),
    .spi_data_in(spi_data_in), .spi_data_out(spi_data_out), .spi_data_oe(spi_data_oe),
    .spi_rwds_in(spi_rwds_in), .spi_rwds_out(spi_rwds_out), .spi_rwds_oe(spi_rwds_oe),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mr_m(input logic [3:0] i);
    case (i)
      4'd0:    return mr0_m;
      4'd1:    return 8'h0D;
      4'd2:    return 8'h93;
      4'd4:    return mr4_m;
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one memory-clock edge; caller is always 1 time unit after a clk edge
  task automatic beat(input logic [7:0] d, input bit m);
    spi_data_in = d;
    spi_rwds_in = m;
    spi_clk     = ~spi_clk;
    tick(2);
  endtask

  task automatic cs_start();
    spi_clk = 1'b0;
    spi_cs  = 1'b1;
    tick(2);
  endtask

  task automatic cs_stop();
    spi_cs = 1'b0;
    tick(1);
    spi_clk = 1'b0;
    tick(2);
    chk("idle_busy", busy, 0);
    chk("idle_oe", {spi_data_oe, spi_rwds_oe}, 0);
    chk("err", err, err_m);
  endtask

  task automatic hdr(input logic [7:0] c, input logic [31:0] a);
    beat(c, 0);
    beat(c, 0);
    for (int i = 3; i >= 0; i--) beat(a[8*i +: 8], 0);
  endtask

  task automatic lat(input bit rd);
    for (int i = 0; i < 2*RD_LAT; i++) begin
      if (i == 0) chk("lat_busy", busy, 1);
      if (rd) begin
        chk("lat_dq_oe", spi_data_oe, 1);
        chk("lat_rwds", {spi_rwds_oe, spi_rwds_out}, 2'b10);
      end else begin
        chk("wlat_oe", {spi_data_oe, spi_rwds_oe}, 0);
      end
      beat(8'h00, 0);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input int n);
    int b;
    b = int'(a[ADDR_W:0]) & ~1;
    cs_start();
    hdr(8'h80, a);
    lat(0);
    for (int i = 0; i < n; i++) begin
      beat(wd[i], wm[i]);
      if (!wm[i]) begin
        mem_m[b] = wd[i];
        vld_m[b] = 1'b1;
      end
      b = (b + 1) % NB;
    end
    cs_stop();
  endtask

  task automatic do_read(input logic [31:0] a, input int n, input bit drop);
    int b;
    b = int'(a[ADDR_W:0]) & ~1;
    cs_start();
    hdr(8'h00, a);
    lat(1);
    for (int i = 0; i < n; i++) begin
      chk("rd_oe", {spi_data_oe, spi_rwds_oe}, 2'b11);
      if (vld_m[b]) chk("rd_data", spi_data_out, mem_m[b]);
      chk("rd_rwds", spi_rwds_out, (b % 2 == 0));
      beat(8'h00, 0);
      b = (b + 1) % NB;
    end
    if (drop) begin
      spi_cs = 1'b0;
      tick(2);
      chk("drop_oe", {spi_data_oe, spi_rwds_oe}, 0);
      chk("drop_busy", busy, 0);
      spi_clk = 1'b0;
      tick(2);
    end else begin
      cs_stop();
    end
  endtask

  task automatic do_mrr(input logic [3:0] idx);
    logic [31:0] a;
    a = $urandom;
    a[3:0] = idx;
    cs_start();
    hdr(8'h40, a);
    lat(1);
    for (int i = 0; i < 2; i++) begin
      chk("mrr_dq", spi_data_out, mr_m(idx));
      chk("mrr_rwds", {spi_rwds_oe, spi_rwds_out}, {1'b1, i == 0});
      beat(8'h00, 0);
    end
    cs_stop();
  endtask

  task automatic do_mrw(input logic [3:0] idx, input logic [7:0] v);
    logic [31:0] a;
    a = $urandom;
    a[3:0] = idx;
    cs_start();
    hdr(8'hC0, a);
    beat(v, 0);
    chk("mrw_oe", {spi_data_oe, spi_rwds_oe}, 0);
    if (idx == 4'd0) mr0_m = v;
    if (idx == 4'd4) mr4_m = v;
    cs_stop();
  endtask

  // reset command or an invalid command pair
  task automatic do_cmd(input logic [7:0] c0, input logic [7:0] c1);
    cs_start();
    beat(c0, 0);
    beat(c1, 0);
    if (c0 != c1 || !(c0 inside {8'h00, 8'h80, 8'h40, 8'hC0, 8'hFF})) err_m = 1'b1;
    else if (c0 == 8'hFF) begin
      mr0_m = 8'h00;
      mr4_m = 8'h00;
    end
    for (int i = 0; i < 3; i++) begin
      chk("cmd_nodrive", {spi_data_oe, spi_rwds_oe}, 0);
      chk("cmd_err", err, err_m);
      beat(8'($urandom), 0);
    end
    cs_stop();
  endtask

  initial begin
    logic [7:0] c0, c1;
    logic [31:0] a;
    int n;
    tick(3);
    chk("rst_out", {spi_data_out, spi_data_oe, spi_rwds_out, spi_rwds_oe}, 0);
    chk("rst_busy_err", {busy, err}, 0);
    reset_n = 1'b1;
    tick(2);

    do_mrr(4'd1);
    do_mrr(4'd2);

    for (int i = 0; i < 8; i++) begin
      wd[i] = 8'($urandom);
      wm[i] = 1'b0;
    end
    do_write(32'h0000_01FC, 8);
    for (int i = 0; i < 8; i++) begin
      wd[i] = 8'((i + 1) * 8'h11);
      wm[i] = (i == 2);
    end
    do_write(32'h0000_01FC, 8);
    do_read(32'h0000_01FC, 8, 0);

    do_mrw(4'd0, 8'h5A);
    do_mrr(4'd0);
    do_cmd(8'hFF, 8'hFF);
    do_mrr(4'd0);
    do_mrw(4'd1, 8'h77);
    do_mrr(4'd1);
    do_mrw(4'd4, 8'hC3);
    do_mrr(4'd4);

    do_read(32'h0000_01FC, 3, 1);
    do_read(32'h0000_01FC, 8, 0);

    for (int it = 0; it < 40; it++) begin
      a = $urandom;
      case ($urandom_range(5))
        0, 1: begin
          n = $urandom_range(8, 1);
          for (int i = 0; i < 8; i++) begin
            wd[i] = 8'($urandom);
            wm[i] = ($urandom_range(3) == 0);
          end
          do_write(a, n);
        end
        2, 3: do_read(a, $urandom_range(8, 1), 0);
        4:    do_mrr(4'($urandom_range(15)));
        default: begin
          if ($urandom_range(1) == 1) do_mrw(($urandom_range(1) == 1) ? 4'd4 : 4'd0, 8'($urandom));
          else do_mrw(4'($urandom_range(15)), 8'($urandom));
        end
      endcase
    end

    do_cmd(8'h00, 8'h80);
    do_read(32'h0000_01FC, 8, 0);
    do_mrr(4'd2);
    for (int it = 0; it < 6; it++) begin
      c0 = 8'($urandom);
      c1 = ($urandom_range(1) == 1) ? c0 : 8'($urandom);
      if (c0 == c1 && (c0 inside {8'h00, 8'h80, 8'h40, 8'hC0, 8'hFF})) c1 = c0 ^ 8'h01;
      do_cmd(c0, c1);
      do_read($urandom, $urandom_range(6, 1), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
